ws_sequencer: RTL and testbench

Hardware sequencer for the weight-stationary `core`. It replaces host-driven stimulus with a registered 34-bit `inst` word that runs the full 3x3 convolution pass:
- per kernel index kij: weight fetch to L0, weight load into the PEs, activation fetch to L0, execute, flush, and OFIFO drain into psum memory;
- then the per-output accumulation sweep.

It sits between the host (start/done) and `core.inst`, and gates `core` reset between passes.

---
 rtl/ws_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ws_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ws_sequencer.sv
// Sequencer for the weight-stationary core: walks the kij loop (fetch, load, execute, flush, drain) on a registered inst word.
// Define WS_SEQ_ACC_EN to compile in the per-output psum accumulation sweep that follows the last kij.
module ws_sequencer #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int gap      = 4
`ifdef WS_SEQ_ACC_EN
  ,
  parameter int len_onij = 16,
  parameter int in_w     = 6,
  parameter int k_w      = 3,
  parameter int o_w      = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_reset,
  output logic        out_strobe,
  output logic [3:0]  onij,
  output logic        busy,
  output logic        done
);

  localparam int CW = 16;
  localparam int AW = 11;

  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] L_CRST  = CW'(1);
  localparam logic [CW-1:0] L_COL   = CW'(col - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(gap - 1);
  localparam logic [CW-1:0] L_NIJ   = CW'(len_nij - 1);
  localparam logic [CW-1:0] L_FLUSH = CW'(row + col - 1);
  localparam logic [CW-1:0] L_KIJ   = CW'(len_kij - 1);
  localparam logic [AW-1:0] XW_BASE = AW'(1024);
  localparam logic [33:0]   IDLE_W  = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

`ifdef WS_SEQ_ACC_EN
  localparam logic [CW-1:0] L_ONIJ  = CW'(len_onij - 1);
  localparam logic [CW-1:0] K_W_M1  = CW'(k_w - 1);
  localparam logic [CW-1:0] O_W_M1  = CW'(o_w - 1);
  localparam logic [AW-1:0] K_STEP  = AW'(len_nij + 1);
  localparam logic [AW-1:0] K_WRAP  = AW'(len_nij + in_w - k_w + 1);
  localparam logic [AW-1:0] O_WRAP  = AW'(in_w - o_w + 1);
  localparam logic [33:0]   ACC_W   = {1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_WL0, S_WLOAD, S_GAP1, S_AL0, S_EXEC, S_FLUSH, S_GAP2, S_DRAIN, S_DONE,
    S_ARST, S_ARD, S_ALAT, S_AOUT
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_WL0, S_WLOAD, S_GAP1, S_AL0, S_EXEC, S_FLUSH, S_GAP2, S_DRAIN, S_DONE
  } state_t;
`endif

  function automatic logic [33:0] mk_inst(
    input logic acc, input logic cen_p, input logic wen_p, input logic [AW-1:0] a_p,
    input logic cen_x, input logic wen_x, input logic [AW-1:0] a_x,
    input logic of_rd, input logic l0_rd, input logic l0_wr, input logic exe, input logic ld);
    return {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x, of_rd, 1'b0, 1'b0, l0_rd, l0_wr, exe, ld};
  endfunction

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d, k, k_d;
  logic [AW-1:0]   wptr, wptr_d, pptr, pptr_d;
  logic [33:0]     inst_d;
  logic            core_reset_d, busy_d, done_d;

`ifdef WS_SEQ_ACC_EN
  logic [CW-1:0]   o, o_d, ocol, ocol_d, kcol, kcol_d;
  logic [AW-1:0]   obase, obase_d, kaddr, kaddr_d;
  logic            strobe_d;
  logic [3:0]      onij_d;
`endif

  // Decision stage: next state and the inst word the core will see next cycle
  always_comb begin
    state_d      = state;
    cnt_d        = cnt + ONE_C;
    k_d          = k;
    wptr_d       = wptr;
    pptr_d       = pptr;
    inst_d       = IDLE_W;
    core_reset_d = 1'b0;
    busy_d       = (state != S_IDLE);
    done_d       = 1'b0;
`ifdef WS_SEQ_ACC_EN
    o_d      = o;
    ocol_d   = ocol;
    obase_d  = obase;
    kcol_d   = kcol;
    kaddr_d  = kaddr;
    strobe_d = 1'b0;
    onij_d   = onij;
`endif
    case (state)
      S_IDLE: begin
        core_reset_d = 1'b1;
        cnt_d        = '0;
        if (start) begin
          state_d = S_CRST;
          k_d     = '0;
          wptr_d  = XW_BASE;
          pptr_d  = '0;
        end
      end
      S_CRST: begin
        core_reset_d = 1'b1;
        if (cnt == L_CRST) begin state_d = S_WL0; cnt_d = '0; end
      end
      S_WL0: begin
        // weight blocks are contiguous across kij, so one running pointer covers 1024+k*col+i
        inst_d = mk_inst(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b1, wptr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wptr_d = wptr + ONE_A;
        if (cnt == L_COL) begin state_d = S_WLOAD; cnt_d = '0; end
      end
      S_WLOAD: begin
        inst_d = mk_inst(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        if (cnt == L_COL) begin state_d = S_GAP1; cnt_d = '0; end
      end
      S_GAP1: begin
        if (cnt == L_GAP) begin state_d = S_AL0; cnt_d = '0; end
      end
      S_AL0: begin
        inst_d = mk_inst(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b1, cnt[AW-1:0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (cnt == L_NIJ) begin state_d = S_EXEC; cnt_d = '0; end
      end
      S_EXEC: begin
        inst_d = mk_inst(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        if (cnt == L_NIJ) begin state_d = S_FLUSH; cnt_d = '0; end
      end
      S_FLUSH: begin
        inst_d = mk_inst(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        if (cnt == L_FLUSH) begin state_d = S_GAP2; cnt_d = '0; end
      end
      S_GAP2: begin
        if (cnt == L_GAP) begin state_d = S_DRAIN; cnt_d = '0; end
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          inst_d = mk_inst(1'b0, 1'b0, 1'b0, pptr, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          pptr_d = pptr + ONE_A;
          if (cnt == L_NIJ) begin
            cnt_d = '0;
            if (k == L_KIJ) begin
`ifdef WS_SEQ_ACC_EN
              state_d = S_ARST;
              o_d     = '0;
              ocol_d  = '0;
              obase_d = '0;
`else
              state_d = S_DONE;
`endif
            end else begin
              k_d     = k + ONE_C;
              state_d = S_CRST;
            end
          end
        end else begin
          // stalled slot: no FIFO pop, no psum write, address held for the retry
          inst_d = mk_inst(1'b0, 1'b1, 1'b0, pptr, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          cnt_d  = cnt;
        end
      end
`ifdef WS_SEQ_ACC_EN
      S_ARST: begin
        core_reset_d = 1'b1;
        onij_d       = o[3:0];
        kaddr_d      = obase;
        kcol_d       = '0;
        state_d      = S_ARD;
        cnt_d        = '0;
      end
      S_ARD: begin
        // acc trails the read by one cycle to cover SRAM read latency
        inst_d = mk_inst(cnt != '0, 1'b0, 1'b1, kaddr, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (kcol == K_W_M1) begin
          kaddr_d = kaddr + K_WRAP;
          kcol_d  = '0;
        end else begin
          kaddr_d = kaddr + K_STEP;
          kcol_d  = kcol + ONE_C;
        end
        if (cnt == L_KIJ) begin state_d = S_ALAT; cnt_d = '0; end
      end
      S_ALAT: begin
        inst_d  = ACC_W;
        state_d = S_AOUT;
        cnt_d   = '0;
      end
      S_AOUT: begin
        strobe_d = 1'b1;
        onij_d   = o[3:0];
        cnt_d    = '0;
        if (o == L_ONIJ) begin
          state_d = S_DONE;
        end else begin
          o_d     = o + ONE_C;
          state_d = S_ARST;
          if (ocol == O_W_M1) begin
            ocol_d  = '0;
            obase_d = obase + O_WRAP;
          end else begin
            ocol_d  = ocol + ONE_C;
            obase_d = obase + ONE_A;
          end
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register stage: state and every output the core and host see
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      k          <= '0;
      wptr       <= XW_BASE;
      pptr       <= '0;
      inst       <= IDLE_W;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      k          <= k_d;
      wptr       <= wptr_d;
      pptr       <= pptr_d;
      inst       <= inst_d;
      core_reset <= core_reset_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

`ifdef WS_SEQ_ACC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o          <= '0;
      ocol       <= '0;
      obase      <= '0;
      kcol       <= '0;
      kaddr      <= '0;
      out_strobe <= 1'b0;
      onij       <= '0;
    end else begin
      o          <= o_d;
      ocol       <= ocol_d;
      obase      <= obase_d;
      kcol       <= kcol_d;
      kaddr      <= kaddr_d;
      out_strobe <= strobe_d;
      onij       <= onij_d;
    end
  end
`else
  assign out_strobe = 1'b0;
  assign onij       = 4'd0;
`endif

endmodule

// File: tb/tb_ws_sequencer.sv
// Bench for ws_sequencer: scripts the expected per-cycle inst/control stream phase by phase against random ofifo_valid.
module tb_ws_sequencer;
  localparam int ROW = 8, COL = 8, NIJ = 36, KIJ = 9, ONIJ = 16;
  localparam int IN_W = 6, K_W = 3, O_W = 4, GAP = 4;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [33:0] inst;
  logic        core_reset, out_strobe, busy, done;
  logic [3:0]  onij;
  logic [3:0]  m_onij;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ws_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .core_reset(core_reset), .out_strobe(out_strobe),
    .onij(onij), .busy(busy), .done(done)
  );

  function automatic logic [33:0] word(input logic acc, input logic cenp, input logic wenp, input int ap,
                                       input logic cenx, input logic wenx, input int ax,
                                       input logic ofrd, input logic l0rd, input logic l0wr,
                                       input logic exe, input logic ld);
    return {acc, cenp, wenp, 11'(ap), cenx, wenx, 11'(ax), ofrd, 2'b00, l0rd, l0wr, exe, ld};
  endfunction

  logic [33:0] IDLE;
  initial IDLE = word(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: outputs after this edge must match the expected decode
  task automatic step(input string tag, input logic [33:0] ei, input logic ecr, input logic ebusy,
                      input logic edone, input logic estb, input logic [3:0] eonij);
    @(posedge clk);
    #1;
    check_val({tag, " inst"}, 64'(inst), 64'(ei));
    check_val({tag, " ctl"}, 64'({core_reset, busy, done, out_strobe, onij}),
              64'({ecr, ebusy, edone, estb, eonij}));
    start       = 1'b0;
    ofifo_valid = 1'($urandom);
  endtask

  task automatic run_pass(input bit abort_exec, input bit stall, input bit extra_start);
    bit v;
    int lows;
    start = 1'b1;
    step("idle_start", IDLE, 1'b1, 1'b0, 1'b0, 1'b0, m_onij);
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < 2; i++) step("crst", IDLE, 1'b1, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < COL; i++)
        step($sformatf("wl0 k%0d i%0d", k, i),
             word(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1024 + k * COL + i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
             1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < COL; i++)
        step($sformatf("wload k%0d", k),
             word(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1),
             1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < GAP; i++) step("gap1", IDLE, 1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < NIJ; i++)
        step($sformatf("al0 k%0d i%0d", k, i),
             word(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
             1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < NIJ; i++) begin
        if (extra_start && k == 1 && i == 3) start = 1'b1;
        step($sformatf("exec k%0d i%0d", k, i),
             word(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0),
             1'b0, 1'b1, 1'b0, 1'b0, m_onij);
        if (abort_exec && k == 0 && i == 10) begin
          reset = 1'b1;
          #1;
          check_val("rst_exec inst", 64'(inst), 64'(IDLE));
          check_val("rst_exec ctl", 64'({core_reset, busy, done, out_strobe, onij}), 64'(8'b1000_0000));
          m_onij = 4'd0;
          @(posedge clk);
          @(posedge clk);
          #1;
          reset = 1'b0;
          start = 1'b0;
          return;
        end
      end
      for (int i = 0; i < ROW + COL; i++)
        step("flush", word(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0),
             1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < GAP; i++) step("gap2", IDLE, 1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      for (int i = 0; i < NIJ; i++) begin
        lows = 0;
        do begin
          if (stall && k == 0 && i == 5 && lows < 3) v = 1'b0;
          else if (lows >= 2) v = 1'b1;
          else v = ($urandom_range(0, 3) != 0);
          ofifo_valid = v;
          step($sformatf("drain k%0d i%0d v%0d", k, i, v),
               v ? word(1'b0, 1'b0, 1'b0, k * NIJ + i, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)
                 : word(1'b0, 1'b1, 1'b0, k * NIJ + i, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
               1'b0, 1'b1, 1'b0, 1'b0, m_onij);
          lows++;
        end while (!v);
      end
    end
`ifdef WS_SEQ_ACC_EN
    for (int o = 0; o < ONIJ; o++) begin
      m_onij = 4'(o);
      step("arst", IDLE, 1'b1, 1'b1, 1'b0, 1'b0, m_onij);
      for (int kk = 0; kk < KIJ; kk++)
        step($sformatf("ard o%0d k%0d", o, kk),
             word(kk != 0, 1'b0, 1'b1,
                  kk * NIJ + (o / O_W + kk / K_W) * IN_W + (o % O_W + kk % K_W),
                  1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      step("alat", word(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b0, 1'b1, 1'b0, 1'b0, m_onij);
      step($sformatf("aout o%0d", o), IDLE, 1'b0, 1'b1, 1'b0, 1'b1, m_onij);
    end
`endif
    step("done", IDLE, 1'b0, 1'b1, 1'b1, 1'b0, m_onij);
    step("idle_end", IDLE, 1'b1, 1'b0, 1'b0, 1'b0, m_onij);
    step("idle_hold", IDLE, 1'b1, 1'b0, 1'b0, 1'b0, m_onij);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    ofifo_valid = 1'b0;
    m_onij      = 4'd0;
    @(posedge clk);
    #1;
    check_val("reset inst", 64'(inst), 64'(IDLE));
    check_val("reset ctl", 64'({core_reset, busy, done, out_strobe, onij}), 64'(8'b1000_0000));
    start = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset start ignored", 64'({busy, core_reset}), 64'(2'b01));
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) step("idle0", IDLE, 1'b1, 1'b0, 1'b0, 1'b0, m_onij);
    run_pass(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("idle_after_rst", IDLE, 1'b1, 1'b0, 1'b0, 1'b0, m_onij);
    run_pass(1'b0, 1'b1, 1'b1);
    run_pass(1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
